wb_arbiter: RTL and testbench

Write-port arbiter for the 32×32 register file: shares its single write port (`w`, `W_Reg`, `W_Data`) between two writeback sources.
- Source 0: main pipeline writeback.
- Source 1: long-latency unit (multiply/divide, load return).

Each source has a one-entry holding buffer. Arbitration is fixed priority with a starvation guard. Writes to register 0 are dropped, and a pending-write query lets decode stall on buffered results. The block sits between the writeback stage(s) and `regfile`.

---
 rtl/wb_arbiter_pkg.sv | 14 +
 rtl/wb_slot.sv | 63 ++++++
 rtl/wb_arbiter.sv | 106 ++++++++++
 tb/tb_wb_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared widths, source ids and defaults for the register-file write-port arbiter.
package wb_arbiter_pkg;

    localparam int WORD_LEN         = 32;
    localparam int REGADDR_LEN      = 5;
    localparam int STARVE_LIMIT_DEF = 4;
    localparam int STARVE_CNT_W     = 4;

    typedef enum logic {
        SRC_PIPE = 1'b0,
        SRC_LONG = 1'b1
    } src_e;

endpackage

// File: rtl/wb_slot.sv
// One-entry writeback holding buffer: accepts when empty or being drained,
// drops writes to register 0, clears on grant unless refilled in the same cycle.
module wb_slot
    import wb_arbiter_pkg::*;
#(
    parameter int W = WORD_LEN,
    parameter int A = REGADDR_LEN
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid_i,
    input  logic [A-1:0] in_reg_i,
    input  logic [W-1:0] in_data_i,
    input  logic         grant_i,
    output logic         ready_o,
    output logic         full_o,
    output logic [A-1:0] reg_o,
    output logic [W-1:0] data_o
);

    logic         full_q, full_d;
    logic [A-1:0] reg_q,  reg_d;
    logic [W-1:0] data_q, data_d;
    logic         ready_s;
    logic         load_s;

    // Ready depends only on held state and the grant, never on in_valid_i.
    always_comb begin
        ready_s = ~rst & (~full_q | grant_i);
        load_s  = in_valid_i & ready_s & (in_reg_i != '0);
        full_d  = full_q;
        reg_d   = reg_q;
        data_d  = data_q;
        if (load_s) begin
            full_d = 1'b1;
            reg_d  = in_reg_i;
            data_d = in_data_i;
        end else if (grant_i) begin
            full_d = 1'b0;
        end else begin
            full_d = full_q;
        end
    end

    // Buffer state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= 1'b0;
            reg_q  <= '0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            reg_q  <= reg_d;
            data_q <= data_d;
        end
    end

    assign ready_o = ready_s;
    assign full_o  = full_q;
    assign reg_o   = reg_q;
    assign data_o  = data_q;

endmodule

// File: rtl/wb_arbiter.sv
// Shares the register-file write port between the pipeline writeback and the
// long-latency unit: fixed priority to the pipeline with a starvation guard.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int W            = WORD_LEN,
    parameter int A            = REGADDR_LEN,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         s0_valid,
    input  logic [A-1:0] s0_reg,
    input  logic [W-1:0] s0_data,
    output logic         s0_ready,
    input  logic         s1_valid,
    input  logic [A-1:0] s1_reg,
    input  logic [W-1:0] s1_data,
    output logic         s1_ready,
    output logic         rf_w,
    output logic [A-1:0] rf_wreg,
    output logic [W-1:0] rf_wdata,
    input  logic [A-1:0] q_reg,
    output logic         q_hit
);

    localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

    logic                    full0_s, full1_s;
    logic [A-1:0]            reg0_s,  reg1_s;
    logic [W-1:0]            data0_s, data1_s;
    logic                    grant0_s, grant1_s;
    src_e                    grant_src_s;
    logic [STARVE_CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    wb_slot #(.W(W), .A(A)) u_slot0 (
        .clk        (clk),
        .rst        (rst),
        .in_valid_i (s0_valid),
        .in_reg_i   (s0_reg),
        .in_data_i  (s0_data),
        .grant_i    (grant0_s),
        .ready_o    (s0_ready),
        .full_o     (full0_s),
        .reg_o      (reg0_s),
        .data_o     (data0_s)
    );

    wb_slot #(.W(W), .A(A)) u_slot1 (
        .clk        (clk),
        .rst        (rst),
        .in_valid_i (s1_valid),
        .in_reg_i   (s1_reg),
        .in_data_i  (s1_data),
        .grant_i    (grant1_s),
        .ready_o    (s1_ready),
        .full_o     (full1_s),
        .reg_o      (reg1_s),
        .data_o     (data1_s)
    );

    // Grant selection, port drive and starvation counter next state.
    always_comb begin
        grant1_s     = full1_s & (~full0_s | (starve_cnt_q == LIMIT));
        grant0_s     = full0_s & ~grant1_s;
        grant_src_s  = grant1_s ? SRC_LONG : SRC_PIPE;
        rf_w         = 1'b0;
        rf_wreg      = '0;
        rf_wdata     = '0;
        starve_cnt_d = starve_cnt_q;
        if (!rst && (grant0_s || grant1_s)) begin
            rf_w     = 1'b1;
            rf_wreg  = (grant_src_s == SRC_LONG) ? reg1_s  : reg0_s;
            rf_wdata = (grant_src_s == SRC_LONG) ? data1_s : data0_s;
        end else begin
            rf_w     = 1'b0;
        end
        if (grant1_s || !full1_s) begin
            starve_cnt_d = '0;
        end else if (grant0_s && starve_cnt_q != LIMIT) begin
            starve_cnt_d = starve_cnt_q + STARVE_CNT_W'(1);
        end else begin
            starve_cnt_d = starve_cnt_q;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // Pending-write lookup for decode; register 0 never reports a hit.
    always_comb begin
        q_hit = 1'b0;
        if (!rst && q_reg != '0) begin
            q_hit = (full0_s & (reg0_s == q_reg)) | (full1_s & (reg1_s == q_reg));
        end else begin
            q_hit = 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed testbench for wb_arbiter with hand-computed expectations.
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        s0_valid, s1_valid;
    logic [4:0]  s0_reg, s1_reg, q_reg;
    logic [31:0] s0_data, s1_data;
    logic        s0_ready, s1_ready;
    logic        rf_w, q_hit;
    logic [4:0]  rf_wreg;
    logic [31:0] rf_wdata;

    int n_checks = 0;
    int n_errors = 0;

    wb_arbiter #(.W(32), .A(5), .STARVE_LIMIT(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .s0_valid (s0_valid),
        .s0_reg   (s0_reg),
        .s0_data  (s0_data),
        .s0_ready (s0_ready),
        .s1_valid (s1_valid),
        .s1_reg   (s1_reg),
        .s1_data  (s1_data),
        .s1_ready (s1_ready),
        .rf_w     (rf_w),
        .rf_wreg  (rf_wreg),
        .rf_wdata (rf_wdata),
        .q_reg    (q_reg),
        .q_hit    (q_hit)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        s0_valid = 1'b0; s0_reg = 5'd0; s0_data = 32'd0;
        s1_valid = 1'b0; s1_reg = 5'd0; s1_data = 32'd0;
        q_reg    = 5'd0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        next_cycle();
        next_cycle();
        #1;
        check("rst_rf_w",     32'(rf_w),     32'd0);
        check("rst_s0_ready", 32'(s0_ready), 32'd0);
        check("rst_s1_ready", 32'(s1_ready), 32'd0);
        check("rst_q_hit",    32'(q_hit),    32'd0);
        next_cycle();
        rst = 1'b0;
        #1;
        check("idle_s0_ready", 32'(s0_ready), 32'd1);
        check("idle_s1_ready", 32'(s1_ready), 32'd1);
        check("idle_rf_w",     32'(rf_w),     32'd0);

        // Uncontested write
        next_cycle();
        s0_valid = 1'b1; s0_reg = 5'd5; s0_data = 32'hDEADBEEF; q_reg = 5'd5;
        #1;
        check("unc_accept_ready", 32'(s0_ready), 32'd1);
        check("unc_pre_rf_w",     32'(rf_w),     32'd0);
        check("unc_pre_q_hit",    32'(q_hit),    32'd0);
        next_cycle();
        s0_valid = 1'b0;
        #1;
        check("unc_rf_w",     32'(rf_w),     32'd1);
        check("unc_rf_wreg",  32'(rf_wreg),  32'd5);
        check("unc_rf_wdata", rf_wdata,      32'hDEADBEEF);
        check("unc_q_hit5",   32'(q_hit),    32'd1);
        q_reg = 5'd6;
        #1;
        check("unc_q_hit6",   32'(q_hit),    32'd0);
        next_cycle();
        q_reg = 5'd5;
        #1;
        check("unc_post_rf_w",  32'(rf_w),  32'd0);
        check("unc_post_q_hit", 32'(q_hit), 32'd0);

        // Register-0 drop
        next_cycle();
        s1_valid = 1'b1; s1_reg = 5'd0; s1_data = 32'h1234; q_reg = 5'd0;
        #1;
        check("r0_s1_ready", 32'(s1_ready), 32'd1);
        next_cycle();
        s1_valid = 1'b0;
        #1;
        check("r0_rf_w",  32'(rf_w),  32'd0);
        check("r0_q_hit", 32'(q_hit), 32'd0);
        next_cycle();
        #1;
        check("r0_rf_w2", 32'(rf_w), 32'd0);

        // Starvation guard: grant pattern 0,0,0,0,1 after the first fill cycle
        for (int t = 0; t <= 10; t++) begin
            next_cycle();
            s0_valid = 1'b1; s0_reg = 5'd1; s0_data = 32'h11;
            s1_valid = 1'b1; s1_reg = 5'd2; s1_data = 32'h22;
            #1;
            if (t == 0) begin
                check("stv_fill_rf_w", 32'(rf_w), 32'd0);
            end else begin
                check("stv_rf_w",     32'(rf_w),     32'd1);
                check("stv_rf_wreg",  32'(rf_wreg),  ((t - 1) % 5 == 4) ? 32'd2 : 32'd1);
                check("stv_rf_wdata", rf_wdata,      ((t - 1) % 5 == 4) ? 32'h22 : 32'h11);
                check("stv_s1_ready", 32'(s1_ready), ((t - 1) % 5 == 4) ? 32'd1 : 32'd0);
                check("stv_s0_ready", 32'(s0_ready), ((t - 1) % 5 == 4) ? 32'd0 : 32'd1);
            end
        end
        // Drain: both full with counter cleared -> pipeline first, then long unit
        next_cycle();
        idle_inputs();
        #1;
        check("drn_wreg0", 32'(rf_wreg), 32'd1);
        next_cycle();
        #1;
        check("drn_wreg1", 32'(rf_wreg), 32'd2);
        next_cycle();
        #1;
        check("drn_empty", 32'(rf_w), 32'd0);

        // Back-to-back source 0
        for (int j = 0; j <= 9; j++) begin
            next_cycle();
            s0_valid = (j < 8);
            s0_reg   = 5'd9;
            s0_data  = (j < 8) ? 32'(j + 1) : 32'd0;
            #1;
            if (j < 8) check("b2b_ready", 32'(s0_ready), 32'd1);
            if (j >= 1 && j <= 8) begin
                check("b2b_rf_w",     32'(rf_w), 32'd1);
                check("b2b_rf_wdata", rf_wdata,  32'(j));
            end else begin
                check("b2b_idle_rf_w", 32'(rf_w), 32'd0);
            end
        end

        // Reset mid-operation
        next_cycle();
        s0_valid = 1'b1; s0_reg = 5'd3; s0_data = 32'h33;
        s1_valid = 1'b1; s1_reg = 5'd4; s1_data = 32'h44;
        next_cycle();
        idle_inputs();
        rst = 1'b1; q_reg = 5'd3;
        #1;
        check("mrst_rf_w",     32'(rf_w),     32'd0);
        check("mrst_s0_ready", 32'(s0_ready), 32'd0);
        check("mrst_s1_ready", 32'(s1_ready), 32'd0);
        check("mrst_q_hit",    32'(q_hit),    32'd0);
        next_cycle();
        rst = 1'b0;
        #1;
        check("mrst_after_s0_ready", 32'(s0_ready), 32'd1);
        check("mrst_after_s1_ready", 32'(s1_ready), 32'd1);
        check("mrst_after_q_hit",    32'(q_hit),    32'd0);
        for (int k = 0; k < 3; k++) begin
            check("mrst_no_write", 32'(rf_w), 32'd0);
            next_cycle();
            #1;
        end

        // Same-register conflict
        s0_valid = 1'b1; s0_reg = 5'd7; s0_data = 32'hA;
        s1_valid = 1'b1; s1_reg = 5'd7; s1_data = 32'hB;
        q_reg = 5'd7;
        #1;
        check("same_s0_ready", 32'(s0_ready), 32'd1);
        check("same_s1_ready", 32'(s1_ready), 32'd1);
        next_cycle();
        s0_valid = 1'b0; s1_valid = 1'b0;
        #1;
        check("same_first_rf_w", 32'(rf_w),    32'd1);
        check("same_first_data", rf_wdata,     32'hA);
        check("same_first_reg",  32'(rf_wreg), 32'd7);
        check("same_first_qhit", 32'(q_hit),   32'd1);
        next_cycle();
        #1;
        check("same_second_rf_w", 32'(rf_w),  32'd1);
        check("same_second_data", rf_wdata,   32'hB);
        check("same_second_qhit", 32'(q_hit), 32'd1);
        next_cycle();
        #1;
        check("same_done_rf_w", 32'(rf_w),  32'd0);
        check("same_done_qhit", 32'(q_hit), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
